// File: rtl/conv_112_49_opt.sv
// Streaming valid-mode 1-D correlation: 112-sample x, 49-tap f, 64 outputs.
// Define CONV_MULT_PIPE_EN to register the product ahead of the accumulator.
module conv_112_49_opt #(
    parameter int N  = 112,
    parameter int M  = 49,
    parameter int XW = 10,
    parameter int YW = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [XW-1:0] f_data,
    input  logic          f_valid,
    output logic          f_ready,
    output logic [YW-1:0] y_data,
    output logic          y_valid,
    input  logic          y_ready
);
    localparam int NO  = N - M + 1;
    localparam int PW  = 2 * XW;
    localparam int XCW = $clog2(N + 1);
    localparam int FCW = $clog2(M + 1);
    localparam int XAW = $clog2(N);
    localparam int MW  = $clog2(NO);
`ifdef CONV_MULT_PIPE_EN
    localparam int LAST = M;
`else
    localparam int LAST = M - 1;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state, state_n;

    logic        [XCW-1:0] xcnt;
    logic        [FCW-1:0] fcnt;
    logic        [MW-1:0]  m;
    logic        [FCW-1:0] j;
    logic        [FCW-1:0] tap;
    logic        [XAW-1:0] xa;
    logic signed [YW-1:0]  acc;
    logic signed [YW-1:0]  mac_in;
    logic signed [YW-1:0]  sum;
    logic signed [PW-1:0]  prod;

    logic signed [XW-1:0] x_mem [N];
    logic signed [XW-1:0] f_mem [M];

    logic x_full, f_full;
    logic x_fire, f_fire, y_fire;
    logic last_step, last_out;

    assign x_full  = xcnt == XCW'(N);
    assign f_full  = fcnt == FCW'(M);
    assign x_ready = !reset && state == S_LOAD && !x_full;
    assign f_ready = !reset && state == S_LOAD && !f_full;
    assign x_fire  = x_valid && x_ready;
    assign f_fire  = f_valid && f_ready;
    assign y_valid = state == S_OUTPUT;
    assign y_fire  = y_valid && y_ready;

    assign last_step = j == FCW'(LAST);
    assign last_out  = m == MW'(NO - 1);

    // The pipelined build steps j one past the last tap; keep the address legal.
    assign tap  = (j < FCW'(M)) ? j : '0;
    assign xa   = XAW'(m) + XAW'(tap);
    assign prod = x_mem[xa] * f_mem[tap];

`ifdef CONV_MULT_PIPE_EN
    logic signed [PW-1:0] prod_q;
    logic                 prod_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_q <= prod;
            prod_v <= state == S_COMPUTE && !last_step;
        end
    end

    assign mac_in = prod_v ? {{(YW-PW){prod_q[PW-1]}}, prod_q} : '0;
`else
    assign mac_in = {{(YW-PW){prod[PW-1]}}, prod};
`endif

    assign sum = acc + mac_in;

    always_ff @(posedge clk) begin
        if (x_fire)
            x_mem[xcnt[XAW-1:0]] <= x_data;
        if (f_fire)
            f_mem[fcnt] <= f_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_LOAD;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_LOAD:
                if (x_full && f_full)
                    state_n = S_COMPUTE;
            S_COMPUTE:
                if (last_step)
                    state_n = S_OUTPUT;
            S_OUTPUT:
                if (y_fire)
                    state_n = last_out ? S_LOAD : S_COMPUTE;
            default:
                state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xcnt   <= '0;
            fcnt   <= '0;
            m      <= '0;
            j      <= '0;
            acc    <= '0;
            y_data <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (x_fire)
                        xcnt <= xcnt + 1'b1;
                    if (f_fire)
                        fcnt <= fcnt + 1'b1;
                    j   <= '0;
                    acc <= '0;
                end
                S_COMPUTE: begin
                    acc <= sum;
                    j   <= j + 1'b1;
                    if (last_step)
                        y_data <= sum;
                end
                S_OUTPUT: begin
                    if (y_fire) begin
                        acc <= '0;
                        j   <= '0;
                        if (last_out) begin
                            m    <= '0;
                            xcnt <= '0;
                            fcnt <= '0;
                        end else begin
                            m <= m + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_112_49_opt.sv
// Bench for conv_112_49_opt: randomized handshakes against a direct
// sum-of-products model of each vector set.
module tb_conv_112_49_opt;
    localparam int N  = 112;
    localparam int M  = 49;
    localparam int NO = 64;
`ifdef CONV_MULT_PIPE_EN
    localparam int LAT = 53;
`else
    localparam int LAT = 52;
`endif
    localparam int WAIT_MAX = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_data = '0;
    logic [9:0]  f_data = '0;
    logic        x_valid = 1'b0;
    logic        f_valid = 1'b0;
    logic        y_ready = 1'b0;
    logic        x_ready, f_ready, y_valid;
    logic [25:0] y_data;

    int xs [N];
    int fs [M];
    logic signed [31:0] expv [NO];
    logic signed [31:0] got [NO];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_112_49_opt dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .f_data  (f_data),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void build_exp();
        for (int k = 0; k < NO; k++) begin
            int s;
            s = 0;
            for (int t = 0; t < M; t++)
                s += xs[k + t] * fs[t];
            expv[k] = s;
        end
    endfunction

    function automatic void set_lin(input int xo, input int fo);
        for (int i = 0; i < N; i++) xs[i] = i + xo;
        for (int i = 0; i < M; i++) fs[i] = i + fo;
        build_exp();
    endfunction

    function automatic void set_const(input int v);
        for (int i = 0; i < N; i++) xs[i] = v;
        for (int i = 0; i < M; i++) fs[i] = v;
        build_exp();
    endfunction

    function automatic void set_rand();
        for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 1023)) - 512;
        for (int i = 0; i < M; i++) fs[i] = int'($urandom_range(0, 1023)) - 512;
        build_exp();
    endfunction

    task automatic feed_x();
        for (int i = 0; i < N; i++) begin
            int t;
            x_valid = 1'b0;
            x_data  = 'x;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x_valid = 1'b1;
            x_data  = xs[i][9:0];
            t = 0;
            while (!x_ready && t < WAIT_MAX) begin
                @(negedge clk);
                t++;
            end
            chk("x_accept_wait", (t < WAIT_MAX) ? 1 : 0, 1);
            @(negedge clk);
        end
        x_valid = 1'b0;
    endtask

    task automatic feed_f();
        for (int i = 0; i < M; i++) begin
            int t;
            f_valid = 1'b0;
            f_data  = 'x;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            f_valid = 1'b1;
            f_data  = fs[i][9:0];
            t = 0;
            while (!f_ready && t < WAIT_MAX) begin
                @(negedge clk);
                t++;
            end
            chk("f_accept_wait", (t < WAIT_MAX) ? 1 : 0, 1);
            @(negedge clk);
        end
        f_valid = 1'b0;
    endtask

    task automatic load_set();
        fork
            feed_x();
            feed_f();
        join
    endtask

    // Consume cnt results; the one at index hold_at is stalled hold_len cycles.
    task automatic collect(input int cnt, input int hold_at, input int hold_len);
        for (int k = 0; k < cnt; k++) begin
            int c;
            int n;
            logic [25:0] held;
            c = 0;
            while (!y_valid && c < LAT + 8) begin
                @(negedge clk);
                c++;
            end
            chk("y_latency", (c <= LAT) ? 1 : 0, 1);
            held = y_data;
            n = (k == hold_at) ? hold_len : int'($urandom_range(0, 2));
            repeat (n) begin
                @(negedge clk);
                chk("y_hold_valid", 32'(y_valid), 1);
                chk("y_hold_data", $signed(y_data), $signed(held));
            end
            got[k] = $signed(y_data);
            chk($sformatf("y_data[%0d]", k), got[k], expv[k]);
            y_ready = 1'b1;
            @(negedge clk);
            y_ready = 1'b0;
        end
    endtask

    task automatic run_set(input int hold_at, input int hold_len);
        load_set();
        collect(NO, hold_at, hold_len);
    endtask

    initial begin
        int seen_valid;
        int not_ready;
        int c;

        repeat (3) @(negedge clk);
        chk("rst_x_ready", 32'(x_ready), 0);
        chk("rst_f_ready", 32'(f_ready), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_y_data", $signed(y_data), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_x_ready", 32'(x_ready), 1);
        chk("post_rst_f_ready", 32'(f_ready), 1);
        @(negedge clk);

        set_lin(-128, -64);
        run_set(10, 20);
        chk("set1_y0", got[0], 213640);
        chk("set1_y1", got[1], 211680);
        chk("set1_y63", got[63], 90160);

        set_lin(-16, -15);
        run_set(-1, 0);
        chk("set2_y0", got[0], 13328);
        chk("set2_y1", got[1], 13769);
        chk("set2_y63", got[63], 41111);

        seen_valid = 0;
        not_ready = 0;
        repeat (100) begin
            @(negedge clk);
            if (y_valid) seen_valid++;
            if (!x_ready || !f_ready) not_ready++;
        end
        chk("idle_y_valid_cycles", seen_valid, 0);
        chk("idle_not_ready_cycles", not_ready, 0);

        set_const(-512);
        run_set(-1, 0);
        chk("ext_y0", got[0], 12845056);
        chk("ext_y63", got[63], 12845056);

        set_rand();
        run_set(5, 3);

        set_lin(-128, -64);
        load_set();
        collect(2, -1, 0);
        c = 0;
        while (!y_valid && c < LAT + 8) begin
            @(negedge clk);
            c++;
        end
        chk("mid_valid_seen", 32'(y_valid), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_y_valid", 32'(y_valid), 0);
        chk("mid_rst_y_data", $signed(y_data), 0);
        chk("mid_rst_x_ready", 32'(x_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_after_x_ready", 32'(x_ready), 1);
        run_set(-1, 0);
        chk("replay_y0", got[0], 213640);
        chk("replay_y63", got[63], 90160);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
